// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB constants, packet types and CRC16 parameters
package usb_pkg;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    typedef enum logic [1:0] {
        PKT_DATA0 = 2'd0,
        PKT_ACK   = 2'd1,
        PKT_NAK   = 2'd2,
        PKT_STALL = 2'd3
    } tx_packet_t;

    localparam int          CRC16_WIDTH = 16;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

    localparam int MAX_PAYLOAD_DEFAULT = 64;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

    function automatic logic [7:0] pid_for(input tx_packet_t t);
        logic [7:0] p;
        case (t)
            PKT_DATA0: p = PID_DATA0;
            PKT_ACK:   p = PID_ACK;
            PKT_NAK:   p = PID_NAK;
            default:   p = PID_STALL;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - byte-wide reflected CRC16 register shared by the TX sequencer and RX checker
module usb_crc16
    import usb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic                   en,
    input  logic [7:0]             data,
    output logic [CRC16_WIDTH-1:0] crc
);

    // LSB-first processing shifts right, so the polynomial is applied bit-reversed.
    localparam logic [15:0] POLY_REF = reflect16(CRC16_POLY);

    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0]) begin
                crc_next = (crc_next >> 1) ^ POLY_REF;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
        end else if (init) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/usb_tx_packet_ctrl.sv
// rtl/usb_tx_packet_ctrl.sv - packet-level TX sequencer: PID, buffered payload, CRC16 to the byte encoder
module usb_tx_packet_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [1:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_FETCH,
        S_LOAD,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_DONE
    } state_t;

    localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

    state_t      state;
    state_t      state_next;
    tx_packet_t  pkt_type;
    logic [6:0]  remaining;
    logic [7:0]  data_reg;
    logic [15:0] crc;
    logic [6:0]  clamped_len;
    logic        start_ok;
    logic        xfer;

    assign xfer        = byte_valid && byte_ready;
    assign start_ok    = (state == S_IDLE) && tx_start;
    assign clamped_len = (buffer_occupancy > MAX_LEN) ? MAX_LEN : buffer_occupancy;

    usb_crc16 u_crc16 (
        .clk  (clk),
        .rst  (rst),
        .init (state == S_PID),
        .en   (state == S_LOAD),
        .data (tx_packet_data),
        .crc  (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake packets latch a zero length so the shared countdown never pops for them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_type  <= PKT_DATA0;
            remaining <= '0;
            data_reg  <= '0;
        end else if (start_ok) begin
            pkt_type  <= tx_packet_t'(tx_packet);
            remaining <= (tx_packet_t'(tx_packet) == PKT_DATA0) ? clamped_len : 7'd0;
        end else if (state == S_LOAD) begin
            data_reg  <= tx_packet_data;
            remaining <= remaining - 7'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (tx_start) state_next = S_PID;
            end
            S_PID: begin
                if (xfer) begin
                    if (pkt_type != PKT_DATA0) state_next = S_DONE;
                    else if (remaining != 7'd0) state_next = S_FETCH;
                    else                        state_next = S_CRC_LO;
                end
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_DATA;
            S_DATA: begin
                if (xfer) state_next = (remaining != 7'd0) ? S_FETCH : S_CRC_LO;
            end
            S_CRC_LO: begin
                if (xfer) state_next = S_CRC_HI;
            end
            S_CRC_HI: begin
                if (xfer) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        get_tx_packet_data = 1'b0;
        byte_out           = 8'h00;
        byte_valid         = 1'b0;
        byte_last          = 1'b0;
        busy               = (state != S_IDLE);
        tx_done            = 1'b0;
        case (state)
            S_PID: begin
                byte_out   = pid_for(pkt_type);
                byte_valid = 1'b1;
                byte_last  = (pkt_type != PKT_DATA0);
            end
            S_FETCH: get_tx_packet_data = 1'b1;
            S_DATA: begin
                byte_out   = data_reg;
                byte_valid = 1'b1;
            end
            S_CRC_LO: begin
                byte_out   = ~crc[7:0];
                byte_valid = 1'b1;
            end
            S_CRC_HI: begin
                byte_out   = ~crc[15:8];
                byte_valid = 1'b1;
                byte_last  = 1'b1;
            end
            S_DONE:  tx_done = 1'b1;
            default: ;
        endcase
    end

endmodule
